// File: rtl/fg_pkg.sv
// Shared timebase definitions: FSM state encoding and default widths that the
// waveform stage also uses.
package fg_pkg;

  localparam int unsigned FgCounterBitwidth   = 32;
  localparam int unsigned FgPrescalerBitwidth = 16;
  localparam int unsigned FgBurstBitwidth     = 16;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StStopping = 2'd2
  } fg_state_e;

endpackage

// File: rtl/fg_prescaler.sv
// Tick divider: counts 0..limit while enabled and emits a tick on the terminal
// count, then wraps. A synchronous clear parks the count at zero.
module fg_prescaler #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clear,
  input  logic             enable,
  input  logic [Width-1:0] limit,
  output logic             tick
);

  logic [Width-1:0] count_q, count_d;

  assign tick = enable && (count_q == limit);

  always_comb begin
    count_d = count_q;
    if (clear || tick) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fg_timebase.sv
// Waveform timebase: prescaled tick, period counter, burst/stop sequencing and
// a one-deep configuration shadow. Burst counting requires FG_TIMEBASE_BURST_EN.
module fg_timebase
  import fg_pkg::*;
#(
  parameter int unsigned COUNTER_BITWIDTH   = FgCounterBitwidth,
  parameter int unsigned PRESCALER_BITWIDTH = FgPrescalerBitwidth
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          en_i,
  input  logic                          start_i,
  input  logic                          stop_i,
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  input  logic [PRESCALER_BITWIDTH-1:0] prescaler_i,
  input  logic [COUNTER_BITWIDTH-1:0]   period_i,
  input  logic [FgBurstBitwidth-1:0]    burst_count_i,
  output logic                          clk_en_o,
  output logic [COUNTER_BITWIDTH-1:0]   CR_o,
  output logic                          running_o,
  output logic                          period_start_o,
  output logic                          done_o
);

  fg_state_e state_q, state_d;

  logic [COUNTER_BITWIDTH-1:0]   cr_q, cr_d;
  logic [COUNTER_BITWIDTH-1:0]   period_act_q, period_act_d;
  logic [COUNTER_BITWIDTH-1:0]   period_sh_q, period_sh_d;
  logic [PRESCALER_BITWIDTH-1:0] presc_act_q, presc_act_d;
  logic [PRESCALER_BITWIDTH-1:0] presc_sh_q, presc_sh_d;
  logic [FgBurstBitwidth-1:0]    remaining_q, remaining_d;
  logic [FgBurstBitwidth-1:0]    burst_load;
  logic                          sh_full_q, sh_full_d;
  logic                          done_q, done_d;

  logic running;
  logic tick;
  logic boundary;
  logic finish;
  logic presc_clear;

`ifdef FG_TIMEBASE_BURST_EN
  assign burst_load = burst_count_i;
`else
  // Continuous runs only; remaining stays zero so bursts never complete.
  logic unused_burst;
  assign unused_burst = ^burst_count_i;
  assign burst_load   = '0;
`endif

  assign running     = (state_q != StIdle);
  assign presc_clear = (state_d == StIdle);

  fg_prescaler #(
    .Width (PRESCALER_BITWIDTH)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clear  (presc_clear),
    .enable (running),
    .limit  (presc_act_q),
    .tick   (tick)
  );

  assign boundary = tick && (cr_q == period_act_q);

  always_comb begin
    state_d     = state_q;
    cr_d        = cr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    finish      = 1'b0;
    if (!en_i) begin
      // Abort: silent return to idle, no completion pulse.
      state_d = StIdle;
      cr_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cr_d = '0;
          if (start_i && !stop_i) begin
            state_d     = StRun;
            remaining_d = burst_load;
          end
        end
        StRun, StStopping: begin
          if (tick) begin
            cr_d = boundary ? '0 : cr_q + COUNTER_BITWIDTH'(1);
          end
          if (boundary && (remaining_q != '0)) begin
            remaining_d = remaining_q - FgBurstBitwidth'(1);
          end
          // Burst completion and a pending stop on the same boundary give one done.
          finish = boundary &&
                   ((state_q == StStopping) || (remaining_q == FgBurstBitwidth'(1)));
          if (finish) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if ((state_q == StRun) && stop_i) begin
            state_d = StStopping;
          end
        end
        default: begin
          state_d = StIdle;
          cr_d    = '0;
        end
      endcase
    end
  end

  // Shadow is promoted while idle, or only on a period boundary while running.
  always_comb begin
    sh_full_d    = sh_full_q;
    presc_sh_d   = presc_sh_q;
    period_sh_d  = period_sh_q;
    presc_act_d  = presc_act_q;
    period_act_d = period_act_q;
    if (sh_full_q && ((state_q == StIdle) || (en_i && boundary))) begin
      presc_act_d  = presc_sh_q;
      period_act_d = period_sh_q;
      sh_full_d    = 1'b0;
    end else if (cfg_valid_i && !sh_full_q) begin
      presc_sh_d  = prescaler_i;
      period_sh_d = period_i;
      sh_full_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= StIdle;
      cr_q         <= '0;
      remaining_q  <= '0;
      done_q       <= 1'b0;
      sh_full_q    <= 1'b0;
      presc_sh_q   <= '0;
      period_sh_q  <= '0;
      presc_act_q  <= '0;
      period_act_q <= '0;
    end else begin
      state_q      <= state_d;
      cr_q         <= cr_d;
      remaining_q  <= remaining_d;
      done_q       <= done_d;
      sh_full_q    <= sh_full_d;
      presc_sh_q   <= presc_sh_d;
      period_sh_q  <= period_sh_d;
      presc_act_q  <= presc_act_d;
      period_act_q <= period_act_d;
    end
  end

  assign clk_en_o       = tick;
  assign CR_o           = cr_q;
  assign running_o      = running;
  assign period_start_o = tick && (cr_q == '0);
  assign done_o         = done_q;
  assign cfg_ready_o    = !sh_full_q;

endmodule

// File: tb/tb_fg_timebase.sv
// Self-checking bench for fg_timebase: directed table, multi-cycle sequences and a
// randomized run against a cycle-level behavioural model.
module tb_fg_timebase;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] prescaler = '0;
  logic [31:0] period = '0;
  logic [15:0] burst = '0;
  logic        clk_en;
  logic [31:0] cr;
  logic        running;
  logic        period_start;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  fg_timebase dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .en_i           (en),
    .start_i        (start),
    .stop_i         (stop),
    .cfg_valid_i    (cfg_valid),
    .cfg_ready_o    (cfg_ready),
    .prescaler_i    (prescaler),
    .period_i       (period),
    .burst_count_i  (burst),
    .clk_en_o       (clk_en),
    .CR_o           (cr),
    .running_o      (running),
    .period_start_o (period_start),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        en, start, stop, cv;
    logic [15:0] presc;
    logic [31:0] per;
    logic        ce, run, ps, dn, rdy;
    logic [31:0] cr;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic e, input logic s, input logic p, input logic v,
                              input int pr, input int pe, input logic ce, input logic run,
                              input logic ps, input logic dn, input logic rdy, input int c);
    vec_t r;
    r.en = e; r.start = s; r.stop = p; r.cv = v;
    r.presc = 16'(pr); r.per = 32'(pe);
    r.ce = ce; r.run = run; r.ps = ps; r.dn = dn; r.rdy = rdy; r.cr = 32'(c);
    return r;
  endfunction

  function automatic logic [63:0] pk(input logic ce, input logic run, input logic ps,
                                     input logic dn, input logic rdy, input logic [31:0] c);
    return {27'd0, ce, run, ps, dn, rdy, c};
  endfunction

  function automatic logic [63:0] outs();
    return pk(clk_en, running, period_start, done, cfg_ready, cr);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic configure(input int p, input int pe);
    int k;
    for (k = 0; k < 20; k++) begin
      if (cfg_ready) break;
      @(negedge clk);
    end
    check("cfg ready before write", 64'(cfg_ready), 64'(1));
    cfg_valid = 1'b1; prescaler = 16'(p); period = 32'(pe);
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
    check("cfg shadow drained in idle", 64'(cfg_ready), 64'(1));
  endtask

  task automatic start_run(input int b);
    start = 1'b1; burst = 16'(b);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cr(input int target, input string name);
    for (int k = 0; k < 40; k++) begin
      if (cr == 32'(target)) break;
      @(negedge clk);
    end
    check(name, 64'(cr), 64'(target));
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 60; k++) begin
      if (done) break;
      @(negedge clk);
    end
    check(name, 64'(done), 64'(1));
  endtask

  // Behavioural model: mode 0 idle, 1 run, 2 stopping.
  int m_mode, m_pc, m_cr, m_rem, m_pa, m_per, m_sh_p, m_sh_per;
  bit m_sh_full, m_done;

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_cr = 0; m_rem = 0; m_pa = 0; m_per = 0;
    m_sh_p = 0; m_sh_per = 0; m_sh_full = 0; m_done = 0;
  endtask

  function automatic bit m_tick();
    return (m_mode != 0) && (m_pc == m_pa);
  endfunction

  task automatic model_step();
    bit t, bnd, promote;
    int rem_before;
    t = m_tick();
    bnd = t && (m_cr == m_per);
    promote = m_sh_full && ((m_mode == 0) || (en && bnd));
    rem_before = m_rem;
    m_done = 0;
    if (!en) begin
      m_mode = 0; m_cr = 0; m_pc = 0;
    end else if (m_mode == 0) begin
      m_cr = 0; m_pc = 0;
      if (start && !stop) begin
        m_mode = 1;
`ifdef FG_TIMEBASE_BURST_EN
        m_rem = int'(burst);
`else
        m_rem = 0;
`endif
      end
    end else begin
      m_pc = t ? 0 : m_pc + 1;
      if (t) m_cr = bnd ? 0 : m_cr + 1;
      if (bnd && m_rem > 0) m_rem--;
      if (bnd && (m_mode == 2 || rem_before == 1)) begin
        m_mode = 0; m_done = 1; m_pc = 0;
      end else if (m_mode == 1 && stop) begin
        m_mode = 2;
      end
    end
    if (promote) begin
      m_pa = m_sh_p; m_per = m_sh_per; m_sh_full = 0;
    end else if (cfg_valid && !m_sh_full) begin
      m_sh_p = int'(prescaler); m_sh_per = int'(period); m_sh_full = 1;
    end
  endtask

  int exp_cr9[9] = '{6, 7, 8, 9, 0, 1, 2, 0, 1};
  bit exp_rdy9[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};

  initial begin
    int tick_t[$];
    int tick_cr[$];
    int ndone, done_at, exp_ticks, n;
    logic [63:0] stop_seq[6];
    logic [63:0] e;

    // Reset state
    cyc(3);
    rstn = 1'b1;
    @(negedge clk);
    check("reset state", outs(), pk(0, 0, 0, 0, 1, 0));

    // Directed table: outputs are those seen one cycle after the row's inputs.
    tbl[0]  = mk(1, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[2]  = mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    tbl[5]  = mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1);
    tbl[6]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2);
    tbl[7]  = mk(1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 2);
    tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[10] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[12] = mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 14; i++) begin
      en = tbl[i].en; start = tbl[i].start; stop = tbl[i].stop; cfg_valid = tbl[i].cv;
      prescaler = tbl[i].presc; period = tbl[i].per; burst = '0;
      @(negedge clk);
      check($sformatf("table row %0d", i), outs(),
            pk(tbl[i].ce, tbl[i].run, tbl[i].ps, tbl[i].dn, tbl[i].rdy, tbl[i].cr));
    end
    en = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    cyc(1);

    // prescaler 3, period 4, burst 2
    configure(3, 4);
    start_run(2);
    ndone = 0; done_at = -1;
    for (int c = 0; c < 60; c++) begin
      if (clk_en) begin tick_t.push_back(c); tick_cr.push_back(int'(cr)); end
      if (done) begin ndone++; done_at = c; end
      @(negedge clk);
    end
`ifdef FG_TIMEBASE_BURST_EN
    exp_ticks = 10;
`else
    exp_ticks = 15;
`endif
    check("burst tick count", 64'(tick_t.size()), 64'(exp_ticks));
    n = (tick_t.size() < exp_ticks) ? tick_t.size() : exp_ticks;
    for (int i = 0; i < n; i++) begin
      check($sformatf("burst tick %0d time", i), 64'(tick_t[i]), 64'(3 + 4 * i));
      check($sformatf("burst tick %0d CR", i), 64'(tick_cr[i]), 64'(i % 5));
    end
`ifdef FG_TIMEBASE_BURST_EN
    check("burst done count", 64'(ndone), 64'(1));
    check("burst done cycle", 64'(done_at), 64'(40));
    check("burst ends idle", 64'(running), 64'(0));
`else
    check("continuous no done", 64'(ndone), 64'(0));
    check("continuous still running", 64'(running), 64'(1));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done("continuous stop done");
    check("continuous idle after stop", 64'(running), 64'(0));
`endif
    cyc(2);

    // Config accepted mid-period takes effect at the next wrap
    configure(0, 9);
    start_run(0);
    wait_cr(5, "wait CR 5 for cfg");
    cfg_valid = 1'b1; prescaler = 16'd0; period = 32'd2;
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("shadow seq %0d CR", i), 64'(cr), 64'(exp_cr9[i]));
      check($sformatf("shadow seq %0d ready", i), 64'(cfg_ready), 64'(exp_rdy9[i]));
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done("shadow run stop done");
    cyc(2);

    // Stop at CR 3 with period 7
    configure(0, 7);
    start_run(0);
    wait_cr(3, "wait CR 3 for stop");
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    stop_seq = '{pk(1, 1, 0, 0, 1, 4), pk(1, 1, 0, 0, 1, 5), pk(1, 1, 0, 0, 1, 6),
                 pk(1, 1, 0, 0, 1, 7), pk(0, 0, 0, 1, 1, 0), pk(0, 0, 0, 0, 1, 0)};
    for (int i = 0; i < 6; i++) begin
      check($sformatf("stopping seq %0d", i), outs(), stop_seq[i]);
      @(negedge clk);
    end

    // prescaler 0, period 0: tick and period start every cycle
    configure(0, 0);
    start_run(0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("every-cycle tick %0d", i), outs(), pk(1, 1, 1, 0, 1, 0));
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("every-cycle stopping", outs(), pk(1, 1, 1, 0, 1, 0));
    @(negedge clk);
    check("every-cycle done", outs(), pk(0, 0, 0, 1, 1, 0));
    cyc(1);

    // Enable drop and asynchronous reset mid-run
    configure(0, 7);
    start_run(0);
    wait_cr(5, "wait CR 5 for abort");
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    check("abort to idle", outs(), pk(0, 0, 0, 0, 1, 0));
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort no done", 64'(ndone), 64'(0));
    start_run(0);
    cyc(2);
    cfg_valid = 1'b1; period = 32'd3;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("shadow full while running", 64'(cfg_ready), 64'(0));
    #2 rstn = 1'b0;
    #1 check("async reset mid-run", outs(), pk(0, 0, 0, 0, 1, 0));
    @(negedge clk);

    // Randomized run against the model
    en = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    rstn = 1'b1;
    model_reset();
    for (int c = 0; c < 2500; c++) begin
      e = pk(m_tick(), m_mode != 0, m_tick() && m_cr == 0, m_done, !m_sh_full, 32'(m_cr));
      check($sformatf("random cycle %0d", c), outs(), e);
      en        = ($urandom_range(0, 39) != 0);
      start     = ($urandom_range(0, 5) == 0);
      stop      = ($urandom_range(0, 19) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      prescaler = 16'($urandom_range(0, 3));
      period    = 32'($urandom_range(0, 5));
      burst     = 16'($urandom_range(0, 3));
      model_step();
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
